// File: rtl/pushshift_pkg.sv
// ============================================================================
// Module  : pushshift_pkg
// Brief   : Default geometry constants and the count-width helper for the
//           push/shift chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pushshift_pkg;

  localparam int c_DEFAULT_DW   = 4;
  localparam int c_DEFAULT_AW   = 4;
  localparam int c_DEFAULT_TAPS = 6;

  // Width needed to hold a stage count from 0 up to and including taps.
  function automatic int countWidth(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pushshift_chainmod_if.sv
// ============================================================================
// Module  : pushshift_chainmod_if
// Brief   : Push-side controls and chain-side status of the push/shift chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pushshift_chainmod_if
  import pushshift_pkg::*;
#(
  parameter int DW   = c_DEFAULT_DW,
  parameter int AW   = c_DEFAULT_AW,
  parameter int TAPS = c_DEFAULT_TAPS
);

  logic                        iEn;
  logic                        iClr;
  logic                        iMode;
  logic [AW-1:0]               iAddr;
  logic [DW-1:0]               iData;
  logic [DW*TAPS-1:0]          oData;
  logic [TAPS-1:0]             oValid;
  logic [countWidth(TAPS)-1:0] oCount;
  logic                        oFull;

  modport master (
    output iEn, iClr, iMode, iAddr, iData,
    input  oData, oValid, oCount, oFull
  );

  modport slave (
    input  iEn, iClr, iMode, iAddr, iData,
    output oData, oValid, oCount, oFull
  );

endinterface

`default_nettype wire

// File: rtl/pushshift_ram.sv
// ============================================================================
// Module  : pushshift_ram
// Brief   : Single-port DW x 2**AW RAM, read-before-write, never reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pushshift_ram
  import pushshift_pkg::*;
#(
  parameter int DW = c_DEFAULT_DW,
  parameter int AW = c_DEFAULT_AW
) (
  input  wire logic          CLOCK,
  input  wire logic          wrEn,
  input  wire logic [AW-1:0] addr,
  input  wire logic [DW-1:0] wrData,
  output logic      [DW-1:0] rdData
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge CLOCK) begin
    if (wrEn) begin
      r_mem[addr] <= wrData;
    end
  end

  // Asynchronous read presents the pre-write word during the writing cycle.
  assign rdData = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/pushshift_chainmod.sv
// ============================================================================
// Module  : pushshift_chainmod
// Brief   : Each push reads a RAM word into stage 0 of a TAPS-deep shift chain.
//           Build macro PUSHSHIFT_BYPASS_EN: mode-0 pushes load iData instead.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pushshift_chainmod
  import pushshift_pkg::*;
#(
  parameter int DW   = c_DEFAULT_DW,
  parameter int AW   = c_DEFAULT_AW,
  parameter int TAPS = c_DEFAULT_TAPS
) (
  input  wire logic             CLOCK,
  input  wire logic             RESET,
  pushshift_chainmod_if.slave   bus
);

  localparam int              CW     = countWidth(TAPS);
  localparam logic [CW-1:0]   c_FULL = CW'(TAPS);

  logic               w_ramWrEn;
  logic [DW-1:0]      w_ramQ;
  logic [DW-1:0]      w_stageIn;
  logic [DW*TAPS-1:0] r_data;
  logic [TAPS-1:0]    r_valid;
  logic [CW-1:0]      r_count;
  logic               r_full;

  assign w_ramWrEn = bus.iEn & ~bus.iClr & ~bus.iMode;

  pushshift_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .CLOCK  (CLOCK),
    .wrEn   (w_ramWrEn),
    .addr   (bus.iAddr),
    .wrData (bus.iData),
    .rdData (w_ramQ)
  );

`ifdef PUSHSHIFT_BYPASS_EN
  assign w_stageIn = bus.iMode ? w_ramQ : bus.iData;
`else
  assign w_stageIn = w_ramQ;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_data  <= '0;
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (bus.iClr) begin
      r_data  <= '0;
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (bus.iEn) begin
      r_data  <= {r_data[DW*(TAPS-1)-1:0], w_stageIn};
      r_valid <= {r_valid[TAPS-2:0], 1'b1};
      if (r_count != c_FULL) begin
        r_count <= r_count + CW'(1);
      end
      // Full once this push brings the count to TAPS, and stays full.
      r_full  <= (r_count >= c_FULL - CW'(1));
    end
  end

  assign bus.oData  = r_data;
  assign bus.oValid = r_valid;
  assign bus.oCount = r_count;
  assign bus.oFull  = r_full;

endmodule

`default_nettype wire

// File: doc/pushshift_chainmod.md
PUSHSHIFT_CHAINMOD -- requirements
Module: pushshift_chainmod

Interface
REQ-001 Parameter DW, default 4, data width per word and per chain stage SHALL be DW bits.
REQ-002 Parameter AW, default 4, address width; RAM depth SHALL be 2**AW words.
REQ-003 Parameter TAPS, default 6, chain stage count; TAPS SHALL be >= 2.
REQ-004 Port CLOCK  in  1  clock; all state SHALL update on the rising edge.
REQ-005 Port RESET  in  1  reset; asynchronous, active-low.
REQ-006 Port iEn  in  1  push strobe; one push per cycle while high.
REQ-007 Port iClr  in  1  synchronous chain clear.
REQ-008 Port iMode  in  1  push mode: 0 = read-then-write, 1 = read-only (no RAM write).
REQ-009 Port iAddr  in  AW  RAM address for the push.
REQ-010 Port iData  in  DW  RAM write data.
REQ-011 Port oData  out  DW*TAPS  chain contents; stage k SHALL occupy bits [DW*k +: DW].
REQ-012 Port oValid  out  TAPS  per-stage valid flags.
REQ-013 Port oCount  out  $clog2(TAPS+1)  number of valid stages.
REQ-014 Port oFull  out  1  high when oCount == TAPS.

Function
REQ-015 On a push, stage 0 SHALL load the pre-write content of RAM[iAddr]; stage k SHALL load stage k-1 for k = 1..TAPS-1; the stage TAPS-1 value SHALL be discarded.
REQ-016 On a push with iMode=0, RAM[iAddr] SHALL be written with iData in the same edge; with iMode=1, the RAM SHALL be unchanged.
REQ-017 Latency: oData, oValid, oCount and oFull SHALL reflect a push on the first rising edge after it; all outputs SHALL be registered.
REQ-018 On a push, oValid SHALL shift left with 1 entering bit 0; oCount SHALL increment and saturate at TAPS.
REQ-019 With iEn low and iClr low, all state SHALL hold.
REQ-020 iClr high SHALL zero all stages, oValid and oCount on the next edge, take priority over iEn, and suppress the RAM write of that cycle.
REQ-021 Pushes at a full chain SHALL continue shifting; oFull SHALL remain high.
REQ-022 Back-to-back pushes to the same address SHALL return the data written by the previous push.

Reset
REQ-023 RESET low SHALL asynchronously clear all stages, oValid, oCount and oFull to 0, including during a push.
REQ-024 RAM contents SHALL NOT be reset and SHALL survive RESET.

Configuration
REQ-025 Macro PUSHSHIFT_BYPASS_EN: when defined, a push with iMode=0 SHALL load iData, not the old RAM word, into stage 0 (write-through).
REQ-026 When PUSHSHIFT_BYPASS_EN is undefined, REQ-015 applies unchanged; REQ-016 applies in both builds.

Structure
REQ-027 Package pushshift_pkg SHALL hold the default DW, AW and TAPS constants and a count-width function.
REQ-028 The RAM SHALL be a sub-module pushshift_ram: single port, read-before-write, unreset, DW x 2**AW.

Verification (defaults DW=4, AW=4, TAPS=6)
REQ-029 Reset, then push mode 0 with addr 0..5 and data 1..6, then mode 1 with addr 0..5 -> oData = 24'h123456 (stage 0 = 6), oValid = 6'h3F, oFull = 1.
REQ-030 Push addr 3 with data A, then addr 3 with data B -> the second push loads stage 0 = A; a mode-1 read of addr 3 -> stage 0 = B.
REQ-031 Eight pushes without clear -> oCount stays 6; the oldest two values are gone from stage 5.
REQ-032 iClr and iEn high together at addr 2 with data F -> chain and oCount = 0; a later mode-1 read of addr 2 shows the old value, not F.
REQ-033 RESET asserted mid-burst between edges -> outputs go to 0 immediately; RAM data written before reset reads back intact.
REQ-034 With PUSHSHIFT_BYPASS_EN defined, push addr 1 with data 9 -> stage 0 = 9 on the next edge.
